// File: rtl/sobel_3x3_gray8.sv
// sobel_3x3_gray8: streaming 3x3 Sobel edge detector on an 8-bit gray raster.
// Two line buffers plus a 3x3 window feed a 3-stage pipeline that emits
// min(|Gx|+|Gy|,255), a thresholded edge bit and the window-centre address.
module sobel_3x3_gray8 #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vsync,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic [7:0]  threshold,
    output logic [7:0]  edge_mag,
    output logic        edge_bin,
    output logic [16:0] edge_addr,
    output logic        edge_valid,
    output logic        frame_done
);
    localparam int            CW       = $clog2(IMG_WIDTH);
    localparam int            NPIX     = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [17:0]   NPIX_I   = 18'(NPIX);
    localparam logic [17:0]   FIRST_I  = 18'(IMG_WIDTH + 1);
    localparam logic [16:0]   LAST_I   = 17'(NPIX - 1);
    localparam logic [16:0]   CTR_OFS  = 17'(IMG_WIDTH + 1);
    localparam logic [16:0]   W17      = 17'(IMG_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    // weighted column/row sum a + 2b + c, max 1020
    function automatic logic [9:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // magnitude of an 11-bit two's complement value in [-1020, 1020]
    function automatic logic [9:0] absv(input logic [10:0] v);
        return v[10] ? 10'(11'd0 - v) : v[9:0];
    endfunction

    // ---------------- input side / stage 1 ----------------
    logic                  vsync_q;
    logic [CW-1:0]         col_q;
    logic [17:0]           idx_q;     // raster index of the next pixel to accept
    logic [2:0][2:0][7:0]  win_q, win_d;  // [row][col], row 0 oldest, col 0 leftmost
    logic                  s1_vld_q;
    logic [16:0]           s1_idx_q;
    logic [CW-1:0]         s1_col_q;

    logic [7:0] lb0 [IMG_WIDTH];  // previous line
    logic [7:0] lb1 [IMG_WIDTH];  // line before that
    logic [7:0] lb0_rd, lb1_rd;
    logic       vsync_rise, accept;

    assign vsync_rise = vsync & ~vsync_q;
    assign accept     = pixel_valid & enable & ~vsync_rise & (idx_q < NPIX_I);
    assign lb0_rd     = lb0[col_q];
    assign lb1_rd     = lb1[col_q];

    // next window: shift left, new right column is {2 lines ago, last line, current}
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb1_rd;
        win_d[1][2] = lb0_rd;
        win_d[2][2] = pixel_in;
    end

    // line buffers: read-before-write at col, no reset (stale rows are border-masked)
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_q] <= lb0_rd;
            lb0[col_q] <= pixel_in;
        end
    end

    // stage 1: counters, window and frame restart on vsync rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q  <= 1'b0;
            col_q    <= '0;
            idx_q    <= '0;
            win_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_col_q <= '0;
        end else begin
            vsync_q <= vsync;
            if (vsync_rise) begin
                col_q    <= '0;
                idx_q    <= '0;
                win_q    <= '0;
                s1_vld_q <= 1'b0;
            end else begin
                s1_vld_q <= accept && (idx_q >= FIRST_I);
                if (accept) begin
                    col_q    <= (col_q == COL_LAST) ? '0 : col_q + COL_ONE;
                    idx_q    <= idx_q + 18'd1;
                    win_q    <= win_d;
                    s1_idx_q <= idx_q[16:0];
                    s1_col_q <= col_q;
                end
            end
        end
    end

    // ---------------- stage 2: gradients ----------------
    logic [9:0]  gxp, gxn, gyp, gyn;
    logic [10:0] gx_d, gy_d;
    logic [16:0] centre;
    logic        bord_d;

    assign gxp    = wsum(win_q[0][2], win_q[1][2], win_q[2][2]);
    assign gxn    = wsum(win_q[0][0], win_q[1][0], win_q[2][0]);
    assign gyp    = wsum(win_q[2][0], win_q[2][1], win_q[2][2]);
    assign gyn    = wsum(win_q[0][0], win_q[0][1], win_q[0][2]);
    assign gx_d   = {1'b0, gxp} - {1'b0, gxn};
    assign gy_d   = {1'b0, gyp} - {1'b0, gyn};
    assign centre = s1_idx_q - CTR_OFS;
    // centre col 0 comes from accepted col 1, centre col W-1 from accepted col 0
    assign bord_d = (centre < W17) || (s1_col_q <= COL_ONE);

    logic        s2_vld_q, bord_q, last_q;
    logic [10:0] gx_q, gy_q;
    logic [16:0] addr_q;

    // stage 2: register Gx/Gy, border flag, centre address and end-of-frame marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            bord_q   <= 1'b0;
            addr_q   <= '0;
            last_q   <= 1'b0;
        end else if (vsync_rise) begin
            s2_vld_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                gx_q   <= gx_d;
                gy_q   <= gy_d;
                bord_q <= bord_d;
                addr_q <= centre;
                last_q <= (s1_idx_q == LAST_I);
            end
        end
    end

    // ---------------- stage 3: magnitude / output ----------------
    logic [10:0] sum;
    logic [7:0]  mag_d;

    assign sum   = {1'b0, absv(gx_q)} + {1'b0, absv(gy_q)};
    assign mag_d = bord_q ? 8'd0 : ((|sum[10:8]) ? 8'hFF : sum[7:0]);

    // stage 3: saturated magnitude, threshold and outputs (held while invalid)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_mag   <= '0;
            edge_bin   <= 1'b0;
            edge_addr  <= '0;
            edge_valid <= 1'b0;
            frame_done <= 1'b0;
        end else if (vsync_rise) begin
            edge_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            edge_valid <= s2_vld_q;
            frame_done <= s2_vld_q & last_q;
            if (s2_vld_q) begin
                edge_mag  <= mag_d;
                edge_bin  <= (mag_d >= threshold);
                edge_addr <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_sobel_3x3_gray8.sv
// tb_sobel_3x3_gray8: directed table-driven bench for sobel_3x3_gray8 on an 8x6 image.
module tb_sobel_3x3_gray8;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NRES = W * H - W - 1;  // 39 results per frame

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, vsync = 1'b0, pixel_valid = 1'b0;
    logic [7:0]  pixel_in = 8'd0, threshold = 8'd0;
    logic [7:0]  edge_mag;
    logic        edge_bin;
    logic [16:0] edge_addr;
    logic        edge_valid, frame_done;

    sobel_3x3_gray8 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .enable(enable), .vsync(vsync),
        .pixel_in(pixel_in), .pixel_valid(pixel_valid), .threshold(threshold),
        .edge_mag(edge_mag), .edge_bin(edge_bin), .edge_addr(edge_addr),
        .edge_valid(edge_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  mag;
        logic        bin;
        logic [16:0] addr;
        logic        fd;
        int          cyc;
    } res_t;
    res_t res[$];
    int   acc_q[$];

    // collect every valid result away from the active edge
    always @(negedge clk)
        if (!rst && edge_valid) res.push_back('{edge_mag, edge_bin, edge_addr, frame_done, cyc});

    // frame vector: stimulus description plus hand-computed expectations
    typedef struct {
        int mode;    // 0 flat 100, 1 step 0|200 at col 4, 2 ramp 10*col
        int thr;
        int gap;     // idle cycles after each pixel
        int ovr;     // enable-low burst mid-line and 12 overrun pixels
        int imag;    // magnitude at interior edge centres
        int n_bin1;  // expected number of edge_bin=1 results
    } fvec_t;
    fvec_t tbl[6];

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] p, input logic en, input logic vs);
        @(negedge clk);
        pixel_valid = v;
        pixel_in    = p;
        enable      = en;
        vsync       = vs;
    endtask

    function automatic logic [7:0] pix_of(input int mode, input int i);
        int c;
        c = i % W;
        case (mode)
            0:       return 8'd100;
            1:       return (c >= 4) ? 8'd200 : 8'd0;
            default: return 8'(10 * c);
        endcase
    endfunction

    // hand rule: borders are 0; step edges at centre cols 3/4; ramp interior is uniform
    function automatic int exp_mag(input int mode, input int a, input int ival);
        int r, c;
        r = a / W;
        c = a % W;
        if (r == 0 || c == 0 || c == W - 1) return 0;
        if (mode == 1) return (c == 3 || c == 4) ? ival : 0;
        return ival;
    endfunction

    task automatic start_frame();
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        drive(1'b0, 8'd0, 1'b1, 1'b0);
        res.delete();
        acc_q.delete();
    endtask

    task automatic run_frame(input fvec_t v);
        start_frame();
        for (int i = 0; i < W * H; i++) begin
            if (v.ovr != 0 && i == 20) repeat (5) drive(1'b1, 8'hFF, 1'b0, 1'b0);
            drive(1'b1, pix_of(v.mode, i), 1'b1, 1'b0);
            acc_q.push_back(cyc + 1);
            repeat (v.gap) drive(1'b0, 8'd0, 1'b1, 1'b0);
        end
        if (v.ovr != 0) repeat (12) drive(1'b1, 8'hFF, 1'b1, 1'b0);
        repeat (6) drive(1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    task automatic check_frame(input fvec_t v, input string nm);
        int nb;
        nb = 0;
        chk($sformatf("%s count", nm), res.size(), NRES);
        foreach (res[k]) begin
            int em;
            em = exp_mag(v.mode, k, v.imag);
            chk($sformatf("%s addr[%0d]", nm, k), int'(res[k].addr), k);
            chk($sformatf("%s mag[%0d]", nm, k), int'(res[k].mag), em);
            chk($sformatf("%s bin[%0d]", nm, k), int'(res[k].bin), (em >= v.thr) ? 1 : 0);
            chk($sformatf("%s fd[%0d]", nm, k), int'(res[k].fd), (k == NRES - 1) ? 1 : 0);
            // accept edge N -> visible after edge N+2 (third edge counting N)
            if (k + W + 1 < acc_q.size())
                chk($sformatf("%s lat[%0d]", nm, k), res[k].cyc - acc_q[k + W + 1], 2);
            nb += int'(res[k].bin);
        end
        chk($sformatf("%s bin1 count", nm), nb, v.n_bin1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        fvec_t v5;
        tbl[0] = '{0, 0,  0, 0, 0,   39};
        tbl[1] = '{1, 64, 0, 0, 255, 8};
        tbl[2] = '{2, 80, 0, 0, 80,  24};
        tbl[3] = '{2, 81, 0, 0, 80,  0};
        tbl[4] = '{1, 64, 1, 0, 255, 8};
        tbl[5] = '{1, 64, 0, 1, 255, 8};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst mag", int'(edge_mag), 0);
        chk("rst bin", int'(edge_bin), 0);
        chk("rst addr", int'(edge_addr), 0);
        chk("rst valid", int'(edge_valid), 0);
        chk("rst fd", int'(frame_done), 0);
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            threshold = 8'(tbl[t].thr);
            run_frame(tbl[t]);
            check_frame(tbl[t], $sformatf("vec%0d", t));
        end

        // vsync rise mid-frame with a pixel in the same cycle
        threshold = 8'd64;
        start_frame();
        for (int i = 0; i < 20; i++) drive(1'b1, pix_of(1, i), 1'b1, 1'b0);
        drive(1'b1, 8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        chk("vs flush +1", int'(edge_valid), 0);
        pixel_valid = 1'b0;
        @(negedge clk);
        chk("vs flush +2", int'(edge_valid), 0);
        vsync = 1'b0;
        res.delete();
        acc_q.delete();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, pix_of(1, i), 1'b1, 1'b0);
            acc_q.push_back(cyc + 1);
        end
        repeat (4) drive(1'b0, 8'd0, 1'b1, 1'b0);
        chk("vs none after 9", res.size(), 0);
        for (int i = 9; i < W * H; i++) begin
            drive(1'b1, pix_of(1, i), 1'b1, 1'b0);
            acc_q.push_back(cyc + 1);
        end
        repeat (6) drive(1'b0, 8'd0, 1'b1, 1'b0);
        v5 = '{1, 64, 0, 0, 255, 8};
        check_frame(v5, "vs_restart");

        // asynchronous reset mid-cycle with non-zero outputs
        start_frame();
        for (int i = 0; i < 21; i++) drive(1'b1, pix_of(1, i), 1'b1, 1'b0);
        repeat (3) drive(1'b0, 8'd0, 1'b1, 1'b0);
        chk("pre-rst valid", int'(edge_valid), 1);
        chk("pre-rst mag", int'(edge_mag), 255);
        chk("pre-rst addr", int'(edge_addr), 11);
        #2 rst = 1'b1;
        #1;
        chk("async rst mag", int'(edge_mag), 0);
        chk("async rst bin", int'(edge_bin), 0);
        chk("async rst addr", int'(edge_addr), 0);
        chk("async rst valid", int'(edge_valid), 0);
        chk("async rst fd", int'(frame_done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
